compare_window_stat: RTL and testbench
======================================

// Module: compare_window_stat
// PURPOSE
//  Downstream consumer of the 8-bit magnitude comparator's QAGB/QAEB/QASB flags.
//  Over a window of WIN_LEN qualified samples, it tallies greater/equal/less
//  results and flags any sample that is not one-hot.
//  At the end of the window it issues a one-cycle Done pulse and a registered
//  majority Verdict. Used to judge operand streams fed through the comparator.
// PARAMETERS
//  CNT_W    8   width of each tally counter (saturating)
//  WIN_LEN  16  qualified samples per window, 1..2^CNT_W-1
// PORTS
//  CLK       in   1      system clock, all logic on rising edge
//  RST       in   1      synchronous, active-high reset
//  Start     in   1      pulse: open a new window (honoured in IDLE only)
//  Abort     in   1      pulse: drop the current window (honoured in RUN only)
//  SampleEn  in   1      comparator flags are valid this cycle
//  QAGB      in   1      comparator A>B
//  QAEB      in   1      comparator A==B
//  QASB      in   1      comparator A<B
//  GtCnt     out  CNT_W  count of A>B samples in the window
//  EqCnt     out  CNT_W  count of A==B samples
//  LtCnt     out  CNT_W  count of A<B samples
//  ErrCnt    out  CNT_W  count of samples whose flags are not one-hot
//  Busy      out  1      high while in RUN
//  Done      out  1      one-cycle pulse at window end
//  Verdict   out  2      10=A>B majority, 01=A<B majority, 00=tie, 11=error seen
// BEHAVIOUR
//  Reset: state=IDLE; all counts, the sample index, Busy, Done and Verdict are 0.
//    Reset mid-window discards the window and produces no Done.
//  FSM IDLE->RUN on Start; RUN->DONE on the WIN_LEN-th accepted sample;
//    RUN->IDLE on Abort; DONE->IDLE unconditionally after 1 cycle.
//  Start while in IDLE:
//    - clears all counts, the sample index and Verdict.
//    - a SampleEn in the same cycle is ignored; counting starts the next cycle.
//  RUN, SampleEn=1: the sample index increments.
//    - exactly one flag set: that counter +1.
//    - otherwise (0, 2 or 3 flags set): ErrCnt +1.
//    - every counter saturates at 2^CNT_W-1 and never wraps.
//  RUN, SampleEn=0: all state holds.
//  Last-sample timing: the last sample is accepted at edge n; Done=1 and
//    Verdict are valid during cycle n+1, so latency is 1 cycle from the last sample.
//  Verdict rules:
//    - ErrCnt!=0 -> 11
//    - else GtCnt>LtCnt -> 10
//    - else LtCnt>GtCnt -> 01
//    - else 00
//    Computed from the final counts, including the last sample.
//  Hold after window end: counts and Verdict hold from Done until the next Start.
//    Busy=0 in IDLE and DONE.
//  Abort in RUN: returns to IDLE with no Done; counts freeze; Verdict stays 0.
//    Abort takes priority over a same-cycle final sample.
//  Ignored inputs: Start in RUN or DONE; Abort outside RUN; SampleEn outside RUN.
//  Sample index width is clog2(WIN_LEN+1), so there is no wrap inside a window.
// TESTING
//  1 Reset, Start, then 16 samples of QAGB=1 -> GtCnt=16, Eq/Lt/Err=0.
//    Done pulses exactly 1 cycle after the 16th SampleEn; Verdict=10.
//  2 Window of 8 QASB, 4 QAEB, 4 QAGB with SampleEn gaps -> LtCnt=8, EqCnt=4,
//    GtCnt=4; Done only after the 16th accepted sample; Verdict=01.
//  3 Inject one sample with QAGB=QASB=1 and one with all flags 0 -> ErrCnt=2,
//    Verdict=11 regardless of the other counts.
//  4 Abort after 5 samples -> Busy falls next cycle, no Done, GtCnt stays 5.
//    A following Start clears all counts to 0.
//  5 RST asserted after 10 samples -> all outputs 0 next cycle, state IDLE.
//    Start+SampleEn in the same cycle -> that sample is not counted.
//  6 CNT_W=3, WIN_LEN=7, then 7 QAEB -> EqCnt=7. Repeat with WIN_LEN=7 and
//    Start held high throughout: second Start ignored, Done once per window.

Source files
------------

// File: rtl/compare_window_stat.sv
// Window statistics over comparator QAGB/QAEB/QASB flags.
// Tallies gt/eq/lt/error samples and registers a majority verdict at window end.
module compare_window_stat #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Abort,
  input  logic             SampleEn,
  input  logic             QAGB,
  input  logic             QAEB,
  input  logic             QASB,
  output logic [CNT_W-1:0] GtCnt,
  output logic [CNT_W-1:0] EqCnt,
  output logic [CNT_W-1:0] LtCnt,
  output logic [CNT_W-1:0] ErrCnt,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Verdict
);

  localparam int IDX_W = $clog2(WIN_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] idx;
  logic [2:0]       flags;
  logic             one_hot;
  logic             take;
  logic             last;
  logic             open;
  logic [CNT_W-1:0] gt_nx, eq_nx, lt_nx, err_nx;
  logic [1:0]       verdict_nx;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             en
  );
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign flags   = {QAGB, QAEB, QASB};
  // odd parity and not all three set means exactly one flag
  assign one_hot = (^flags) && !(&flags);
  assign open    = (state == IDLE) && Start;
  assign take    = (state == RUN) && SampleEn && !Abort;
  assign last    = take && (idx == LAST_IDX);

  always_comb begin
    gt_nx  = sat_inc(GtCnt, take && one_hot && QAGB);
    eq_nx  = sat_inc(EqCnt, take && one_hot && QAEB);
    lt_nx  = sat_inc(LtCnt, take && one_hot && QASB);
    err_nx = sat_inc(ErrCnt, take && !one_hot);
  end

  always_comb begin
    verdict_nx = 2'b00;
    if (err_nx != '0)
      verdict_nx = 2'b11;
    else if (gt_nx > lt_nx)
      verdict_nx = 2'b10;
    else if (lt_nx > gt_nx)
      verdict_nx = 2'b01;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (Start) state_nx = RUN;
      RUN: begin
        if (Abort)
          state_nx = IDLE;
        else if (last)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST || open) begin
      GtCnt   <= '0;
      EqCnt   <= '0;
      LtCnt   <= '0;
      ErrCnt  <= '0;
      idx     <= '0;
      Verdict <= 2'b00;
    end else if (take) begin
      GtCnt  <= gt_nx;
      EqCnt  <= eq_nx;
      LtCnt  <= lt_nx;
      ErrCnt <= err_nx;
      idx    <= idx + IDX_W'(1);
      if (last)
        Verdict <= verdict_nx;
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_compare_window_stat.sv
// Directed bench for compare_window_stat: window results are queued when the
// last sample is driven and checked when Done appears.
module tb_compare_window_stat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, abort, en, gt, eq, lt;
  logic [7:0] gt_c, eq_c, lt_c, err_c;
  logic       busy, done;
  logic [1:0] verdict;

  logic       start2, abort2, en2, gt2, eq2, lt2;
  logic [2:0] gt_c2, eq_c2, lt_c2, err_c2;
  logic       busy2, done2;
  logic [1:0] verdict2;

  compare_window_stat #(.CNT_W(8), .WIN_LEN(16)) dut (
    .CLK(clk), .RST(rst), .Start(start), .Abort(abort),
    .SampleEn(en), .QAGB(gt), .QAEB(eq), .QASB(lt),
    .GtCnt(gt_c), .EqCnt(eq_c), .LtCnt(lt_c), .ErrCnt(err_c),
    .Busy(busy), .Done(done), .Verdict(verdict)
  );

  compare_window_stat #(.CNT_W(3), .WIN_LEN(7)) dut2 (
    .CLK(clk), .RST(rst), .Start(start2), .Abort(abort2),
    .SampleEn(en2), .QAGB(gt2), .QAEB(eq2), .QASB(lt2),
    .GtCnt(gt_c2), .EqCnt(eq_c2), .LtCnt(lt_c2), .ErrCnt(err_c2),
    .Busy(busy2), .Done(done2), .Verdict(verdict2)
  );

  typedef struct {
    logic [31:0] g;
    logic [31:0] e;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] v;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t x1, x2;
  int checks = 0;
  int errors = 0;
  int ndone1 = 0;
  int ndone2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic e, input logic g, input logic q,
                     input logic l);
    en = e; gt = g; eq = q; lt = l;
    step();
    en = 0; gt = 0; eq = 0; lt = 0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      ndone1++;
      checks++;
      assert (q1.size() != 0) else begin
        errors++;
        $error("FAIL dut1_done observed=1 expected=0");
      end
      if (q1.size() != 0) begin
        x1 = q1.pop_front();
        chk("dut1_gt", 32'(gt_c), x1.g);
        chk("dut1_eq", 32'(eq_c), x1.e);
        chk("dut1_lt", 32'(lt_c), x1.l);
        chk("dut1_err", 32'(err_c), x1.r);
        chk("dut1_verdict", 32'(verdict), x1.v);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      ndone2++;
      checks++;
      assert (q2.size() != 0) else begin
        errors++;
        $error("FAIL dut2_done observed=1 expected=0");
      end
      if (q2.size() != 0) begin
        x2 = q2.pop_front();
        chk("dut2_gt", 32'(gt_c2), x2.g);
        chk("dut2_eq", 32'(eq_c2), x2.e);
        chk("dut2_lt", 32'(lt_c2), x2.l);
        chk("dut2_err", 32'(err_c2), x2.r);
        chk("dut2_verdict", 32'(verdict2), x2.v);
      end
    end
  end

  initial begin
    rst = 1;
    start = 0; abort = 0; en = 0; gt = 0; eq = 0; lt = 0;
    start2 = 0; abort2 = 0; en2 = 0; gt2 = 0; eq2 = 0; lt2 = 0;
    step();
    step();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_gt", 32'(gt_c), 0);
    chk("rst_eq", 32'(eq_c), 0);
    chk("rst_lt", 32'(lt_c), 0);
    chk("rst_err", 32'(err_c), 0);
    chk("rst_verdict", 32'(verdict), 0);
    chk("rst2_busy", 32'(busy2), 0);

    // 1: sixteen A>B samples
    start = 1;
    step();
    start = 0;
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 15; i++) smp(1, 1, 0, 0);
    chk("t1_no_early_done", 32'(done), 0);
    q1.push_back('{16, 0, 0, 0, 2});
    smp(1, 1, 0, 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_verdict", 32'(verdict), 2);
    step();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_hold_gt", 32'(gt_c), 16);
    chk("t1_hold_verdict", 32'(verdict), 2);

    // 2: mixed window with gaps and an ignored Start in RUN
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) smp(0, 1, 1, 1);
      if (i == 5) start = 1;
      if (i == 15) q1.push_back('{4, 4, 8, 0, 1});
      if (i < 8)       smp(1, 0, 0, 1);
      else if (i < 12) smp(1, 0, 1, 0);
      else             smp(1, 1, 0, 0);
      start = 0;
      if (i == 14) chk("t2_no_early_done", 32'(done), 0);
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_lt", 32'(lt_c), 8);
    step();

    // 3: error samples force verdict 11
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 14; i++) smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    q1.push_back('{14, 0, 0, 2, 3});
    smp(1, 0, 0, 0);
    chk("t3_done", 32'(done), 1);
    chk("t3_err", 32'(err_c), 2);
    step();

    // 4: abort after five samples, then abort beating a final sample
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 5; i++) smp(1, 1, 0, 0);
    abort = 1;
    step();
    abort = 0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_gt", 32'(gt_c), 5);
    chk("t4_verdict", 32'(verdict), 0);
    step();
    chk("t4_gt_frozen", 32'(gt_c), 5);
    start = 1;
    step();
    start = 0;
    chk("t4_clear_gt", 32'(gt_c), 0);
    for (int i = 0; i < 15; i++) smp(1, 1, 0, 0);
    abort = 1;
    smp(1, 1, 0, 0);
    abort = 0;
    chk("t4b_busy", 32'(busy), 0);
    chk("t4b_gt", 32'(gt_c), 15);
    chk("t4b_done", 32'(done), 0);
    step();
    chk("t4b_done_later", 32'(done), 0);

    // 5: Start with a same-cycle sample, then reset mid-window
    start = 1;
    smp(1, 1, 0, 0);
    start = 0;
    for (int i = 0; i < 10; i++) smp(1, 1, 0, 0);
    chk("t5_gt", 32'(gt_c), 10);
    rst = 1;
    step();
    rst = 0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_gt_rst", 32'(gt_c), 0);
    chk("t5_verdict", 32'(verdict), 0);
    smp(1, 1, 0, 0);
    chk("t5_idle_sample", 32'(gt_c), 0);
    chk("t5_idle_busy", 32'(busy), 0);

    // 6: narrow counters, Start held high across two windows
    q2.push_back('{0, 7, 0, 0, 0});
    q2.push_back('{0, 7, 0, 0, 0});
    start2 = 1; en2 = 1; eq2 = 1;
    repeat (18) step();
    start2 = 0; en2 = 0; eq2 = 0;
    step();
    step();
    chk("t6_done_count", 32'(ndone2), 2);
    chk("t6_busy", 32'(busy2), 0);
    chk("t6_eq", 32'(eq_c2), 7);

    // 6b: last sample breaks a tie
    start2 = 1;
    step();
    start2 = 0;
    for (int i = 0; i < 7; i++) begin
      en2 = 1;
      gt2 = (i < 3);
      lt2 = (i >= 3);
      if (i == 6) q2.push_back('{3, 0, 4, 0, 1});
      step();
    end
    en2 = 0; gt2 = 0; lt2 = 0;
    chk("t6b_done", 32'(done2), 1);
    step();

    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    chk("dut1_done_count", 32'(ndone1), 3);
    chk("dut2_done_count", 32'(ndone2), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
